devtbl_gen: RTL and testbench



---
 rtl/devtbl_pkg.sv | 19 +
 rtl/devtbl_rstchan.sv | 32 +++
 rtl/devtbl_gen.sv | 86 ++++++++
 tb/tb_devtbl_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/devtbl_pkg.sv
// devtbl_pkg: bus op codes, query/command/status codes and clog2 for the device table
package devtbl_pkg;
  typedef enum logic [1:0] {OP_NOOP = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_RW = 2'b11} pi1_op_e;
  typedef enum logic [7:0] {CMD_PULSE = 8'd0, CMD_SET = 8'd1, CMD_CLR = 8'd2, CMD_LOCK = 8'd3} cmd_e;
  localparam int Q_SOCVER = 0;
  localparam int Q_RAMCACHE = 1;
  localparam int Q_RSTSTAT = 2;
  localparam int Q_PRELDR = 3;
  localparam int Q_DEVCNT = 4;
  localparam int Q_RSTCNT = 5;
  localparam logic ST_OK = 1'b0;
  localparam logic ST_ERR = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction
endpackage

// File: rtl/devtbl_rstchan.sv
// devtbl_rstchan: one reset channel with a held bit and a timed pulse counter
module devtbl_rstchan import devtbl_pkg::*; #(
  parameter int RSTPULSE = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pulse,
  input  logic set,
  input  logic clr,
  output logic rst
);
  localparam int CW = clog2(RSTPULSE + 1);
  logic held, held_n;
  logic [CW-1:0] cnt, cnt_n;
  // clear wins over everything; a pulse reloads the count, otherwise it runs down to zero
  always_comb begin
    held_n = clr ? 1'b0 : held | set;
    cnt_n = clr ? '0 : pulse ? CW'(RSTPULSE) : (cnt != '0) ? cnt - 1'b1 : '0;
  end
  // output is registered from the next-state values so a command shows on the very next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held <= 1'b0;
      cnt <= '0;
      rst <= 1'b0;
    end else begin
      held <= held_n;
      cnt <= cnt_n;
      rst <= held_n | (cnt_n != '0);
    end
  end
endmodule

// File: rtl/devtbl_gen.sv
// devtbl_gen: parametrised device-table peripheral with SoC queries and reset channels
module devtbl_gen import devtbl_pkg::*; #(
  parameter int ARCHBITSZ = 32,
  localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  parameter int DEVCNT = 5,
  parameter logic [8*DEVCNT-1:0] DEVIDS = {8'd1, 8'd5, 8'd3, 8'd7, 8'd4},
  parameter logic [ADDRBITSZ*DEVCNT-1:0] DEVMAPSZS = {30'h100000, 30'd2, 30'd2, 30'd880, 30'd128},
  parameter logic [DEVCNT-1:0] DEVINTRS = 5'b01001,
  parameter int RSTCNT = 2,
  parameter int RSTPULSE = 16,
  parameter int MAPSZ = 880,
  parameter logic [ARCHBITSZ-1:0] SOCVERSION = '0,
  parameter logic [ARCHBITSZ-1:0] RAMCACHESZ = '0,
  parameter logic [ARCHBITSZ-1:0] PRELDRADDR = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             pi1_op_i,
  input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o,
  output logic [ADDRBITSZ-1:0]   pi1_mapsz_o,
  output logic [RSTCNT-1:0]      rst_o,
  output logic                   pldr_o
);
  logic [ADDRBITSZ-1:0] ent;
  logic [ARCHBITSZ-1:0] rd_val, q_val, data_n;
  logic [7:0] cmd, ch;
  logic cmd_en, err, act, lock_cmd, upd, lock;
  logic unused_sel;
  assign pi1_rdy_o = 1'b1;
  assign pi1_mapsz_o = ADDRBITSZ'(MAPSZ);
  assign unused_sel = ^pi1_sel_i;
  assign ent = pi1_addr_i >> 1;
  assign cmd = pi1_data_i[7:0];
  assign ch = pi1_data_i[15:8];
  // table lookup: even word is the device id, odd word is byte-scaled map size with the interrupt flag in bit 0
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < DEVCNT; i++)
      if (ent == ADDRBITSZ'(i))
        rd_val = pi1_addr_i[0] ? {DEVMAPSZS[i*ADDRBITSZ +: ADDRBITSZ], {(ARCHBITSZ-ADDRBITSZ-1){1'b0}}, DEVINTRS[i]}
                               : ARCHBITSZ'(DEVIDS[i*8 +: 8]);
  end
  // query decode, command decode and the response word
  always_comb begin
    q_val = (pi1_data_i == ARCHBITSZ'(Q_SOCVER))   ? SOCVERSION :
            (pi1_data_i == ARCHBITSZ'(Q_RAMCACHE)) ? RAMCACHESZ :
            (pi1_data_i == ARCHBITSZ'(Q_RSTSTAT))  ? ARCHBITSZ'(rst_o) :
            (pi1_data_i == ARCHBITSZ'(Q_PRELDR))   ? (lock ? '0 : PRELDRADDR) :
            (pi1_data_i == ARCHBITSZ'(Q_DEVCNT))   ? ARCHBITSZ'(DEVCNT) :
            (pi1_data_i == ARCHBITSZ'(Q_RSTCNT))   ? ARCHBITSZ'(RSTCNT) : '0;
    cmd_en = (pi1_op_i == OP_RW) && (pi1_addr_i == ADDRBITSZ'(1));
    err = (cmd > CMD_LOCK) || ((cmd != CMD_LOCK) && (ch >= 8'(RSTCNT)));
    act = cmd_en && !err;
    lock_cmd = act && (cmd == CMD_LOCK);
    upd = (pi1_op_i == OP_RD) || (pi1_op_i == OP_RW);
    data_n = (pi1_op_i == OP_RD) ? rd_val :
             (pi1_addr_i == ADDRBITSZ'(0)) ? q_val :
             (pi1_addr_i == ADDRBITSZ'(1)) ? ARCHBITSZ'(err ? ST_ERR : ST_OK) : '0;
  end
  // response register, sticky lock and one-cycle preloader strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pi1_data_o <= '0;
      lock <= 1'b0;
      pldr_o <= 1'b0;
    end else begin
      if (upd) pi1_data_o <= data_n;
      lock <= lock | lock_cmd;
      pldr_o <= lock_cmd;
    end
  end
  for (genvar c = 0; c < RSTCNT; c++) begin : g_ch
    devtbl_rstchan #(.RSTPULSE(RSTPULSE)) u_ch (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .pulse (act && (cmd == CMD_PULSE) && (ch == 8'(c))),
      .set   (act && (cmd == CMD_SET) && (ch == 8'(c))),
      .clr   (act && (cmd == CMD_CLR) && (ch == 8'(c))),
      .rst   (rst_o[c])
    );
  end
endmodule

// File: tb/tb_devtbl_gen.sv
// tb_devtbl_gen: scoreboard bench for the device-table peripheral
module tb_devtbl_gen;
  typedef struct {
    logic [1:0]  o;
    logic [29:0] a;
    logic [31:0] d;
    logic [31:0] x;
    logic [1:0]  xr;
  } stim_t;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [1:0] op = 2'b00;
  logic [29:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [3:0] sel = 4'hf;
  logic rdy, pldr;
  logic [29:0] mapsz;
  logic [1:0] rst_o;
  logic [31:0] sb[$];
  logic [31:0] e;
  int tests = 0;
  int fails = 0;
  devtbl_gen #(.PRELDRADDR(32'h1000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pi1_op_i(op), .pi1_addr_i(addr), .pi1_data_i(din),
    .pi1_data_o(dout), .pi1_sel_i(sel), .pi1_rdy_o(rdy), .pi1_mapsz_o(mapsz),
    .rst_o(rst_o), .pldr_o(pldr)
  );
  always #5 clk_i = ~clk_i;
  task automatic drive(input logic [1:0] o, input logic [29:0] a, input logic [31:0] d);
    op = o;
    addr = a;
    din = d;
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset;
    rst_ni = 1'b0;
    drive(2'b10, 30'd1, 0);
    repeat (3) tick();
    tests += 5;
    if (dout !== 32'h0) begin fails++; $display("FAIL reset data_o=%h expected 0", dout); end
    if (rst_o !== 2'b00) begin fails++; $display("FAIL reset rst_o=%b expected 00", rst_o); end
    if (pldr !== 1'b0) begin fails++; $display("FAIL reset pldr_o=%b expected 0", pldr); end
    if (rdy !== 1'b1) begin fails++; $display("FAIL reset rdy=%b expected 1", rdy); end
    if (mapsz !== 30'd880) begin fails++; $display("FAIL reset mapsz=%0d expected 880", mapsz); end
    drive(2'b00, 0, 0);
    rst_ni = 1'b1;
    tick();
    tests++;
    if (dout !== 32'h0) begin fails++; $display("FAIL release data_o=%h expected 0", dout); end
  endtask
  task automatic test_table;
    stim_t s[7];
    s = '{'{2'b10, 30'd1, 0, 32'h201, 2'b00}, '{2'b10, 30'd0, 0, 32'h4, 2'b00},
          '{2'b10, 30'd10, 0, 32'h0, 2'b00}, '{2'b10, 30'd9, 0, 32'h400000, 2'b00},
          '{2'b10, 30'd6, 0, 32'h5, 2'b00}, '{2'b10, 30'd3, 0, 32'hdc0, 2'b00},
          '{2'b10, 30'd7, 0, 32'h9, 2'b00}};
    for (int i = 0; i < 7; i++) begin
      drive(s[i].o, s[i].a, s[i].d);
      sb.push_back(s[i].x);
      tick();
      e = sb.pop_front();
      tests++;
      if (dout !== e) begin fails++; $display("FAIL table[%0d] data_o=%h expected %h", i, dout, e); end
    end
  endtask
  task automatic test_query;
    stim_t s[9];
    s = '{'{2'b11, 30'd0, 32'd4, 32'd5, 2'b00}, '{2'b11, 30'd0, 32'd5, 32'd2, 2'b00},
          '{2'b01, 30'd0, 32'd4, 32'd2, 2'b00}, '{2'b11, 30'd0, 32'd9, 32'd0, 2'b00},
          '{2'b11, 30'd0, 32'd3, 32'h1000, 2'b00}, '{2'b00, 30'd0, 32'd4, 32'h1000, 2'b00},
          '{2'b11, 30'd0, 32'd1, 32'd0, 2'b00}, '{2'b11, 30'd0, 32'd4, 32'd5, 2'b00},
          '{2'b11, 30'd2, 32'd4, 32'd0, 2'b00}};
    for (int i = 0; i < 9; i++) begin
      drive(s[i].o, s[i].a, s[i].d);
      sb.push_back(s[i].x);
      tick();
      e = sb.pop_front();
      tests++;
      if (dout !== e) begin fails++; $display("FAIL query[%0d] data_o=%h expected %h", i, dout, e); end
    end
    drive(2'b00, 0, 0);
  endtask
  task automatic test_pulse;
    drive(2'b11, 30'd1, 32'h100);
    sb.push_back(32'h0);
    tick();
    drive(2'b00, 0, 0);
    e = sb.pop_front();
    tests++;
    if (dout !== e) begin fails++; $display("FAIL pulse_ack data_o=%h expected %h", dout, e); end
    for (int k = 1; k <= 17; k++) begin
      tests++;
      if (rst_o !== (k <= 16 ? 2'b10 : 2'b00)) begin fails++; $display("FAIL pulse t+%0d rst_o=%b expected %b", k, rst_o, (k <= 16 ? 2'b10 : 2'b00)); end
      tick();
    end
  endtask
  task automatic test_back_to_back;
    for (int k = 0; k <= 28; k++) begin
      drive((k == 0 || k == 10) ? 2'b11 : 2'b00, 30'd1, 32'h0);
      tick();
      tests++;
      if (rst_o !== ((k + 1) <= 26 ? 2'b01 : 2'b00)) begin fails++; $display("FAIL repulse t+%0d rst_o=%b expected %b", k + 1, rst_o, ((k + 1) <= 26 ? 2'b01 : 2'b00)); end
    end
    for (int k = 0; k <= 42; k++) begin
      drive((k == 0 || k == 5 || k == 10 || k == 40) ? 2'b11 : 2'b00, 30'd1,
            k == 5 ? 32'h1 : k == 40 ? 32'h2 : 32'h0);
      tick();
      tests++;
      if (rst_o !== ((k + 1) <= 40 ? 2'b01 : 2'b00)) begin fails++; $display("FAIL set_clear t+%0d rst_o=%b expected %b", k + 1, rst_o, ((k + 1) <= 40 ? 2'b01 : 2'b00)); end
    end
    drive(2'b00, 0, 0);
  endtask
  task automatic test_errors;
    stim_t s[7];
    s = '{'{2'b11, 30'd1, 32'h500, 32'd1, 2'b00}, '{2'b11, 30'd1, 32'h7, 32'd1, 2'b00},
          '{2'b11, 30'd1, 32'h200, 32'd1, 2'b00}, '{2'b11, 30'd1, 32'h101, 32'd0, 2'b10},
          '{2'b11, 30'd0, 32'h2, 32'd2, 2'b10}, '{2'b11, 30'd1, 32'h102, 32'd0, 2'b00},
          '{2'b11, 30'd0, 32'h2, 32'd0, 2'b00}};
    for (int i = 0; i < 7; i++) begin
      drive(s[i].o, s[i].a, s[i].d);
      sb.push_back(s[i].x);
      tick();
      e = sb.pop_front();
      tests += 2;
      if (dout !== e) begin fails++; $display("FAIL err[%0d] data_o=%h expected %h", i, dout, e); end
      if (rst_o !== s[i].xr) begin fails++; $display("FAIL err[%0d] rst_o=%b expected %b", i, rst_o, s[i].xr); end
    end
    drive(2'b00, 0, 0);
  endtask
  task automatic test_lock;
    drive(2'b11, 30'd1, 32'h3);
    sb.push_back(32'h0);
    tests++;
    if (pldr !== 1'b0) begin fails++; $display("FAIL lock_pre pldr_o=%b expected 0", pldr); end
    tick();
    drive(2'b00, 0, 0);
    e = sb.pop_front();
    tests += 2;
    if (dout !== e) begin fails++; $display("FAIL lock_ack data_o=%h expected %h", dout, e); end
    if (pldr !== 1'b1) begin fails++; $display("FAIL lock_strobe pldr_o=%b expected 1", pldr); end
    tick();
    tests++;
    if (pldr !== 1'b0) begin fails++; $display("FAIL lock_after pldr_o=%b expected 0", pldr); end
    drive(2'b11, 30'd0, 32'h3);
    sb.push_back(32'h0);
    tick();
    e = sb.pop_front();
    tests++;
    if (dout !== e) begin fails++; $display("FAIL locked_q3 data_o=%h expected %h", dout, e); end
    drive(2'b11, 30'd1, 32'h3);
    tick();
    drive(2'b00, 0, 0);
    tests++;
    if (pldr !== 1'b1) begin fails++; $display("FAIL relock pldr_o=%b expected 1", pldr); end
    drive(2'b11, 30'd1, 32'h100);
    tick();
    drive(2'b00, 0, 0);
    repeat (3) tick();
    tests++;
    if (rst_o !== 2'b10) begin fails++; $display("FAIL mid_pulse rst_o=%b expected 10", rst_o); end
    #2 rst_ni = 1'b0;
    #1;
    tests += 3;
    if (rst_o !== 2'b00) begin fails++; $display("FAIL async_rst rst_o=%b expected 00", rst_o); end
    if (dout !== 32'h0) begin fails++; $display("FAIL async_rst data_o=%h expected 0", dout); end
    if (pldr !== 1'b0) begin fails++; $display("FAIL async_rst pldr_o=%b expected 0", pldr); end
    tick();
    rst_ni = 1'b1;
    drive(2'b11, 30'd0, 32'h3);
    sb.push_back(32'h1000);
    tick();
    drive(2'b00, 0, 0);
    e = sb.pop_front();
    tests += 2;
    if (dout !== e) begin fails++; $display("FAIL unlocked_q3 data_o=%h expected %h", dout, e); end
    if (rst_o !== 2'b00) begin fails++; $display("FAIL post_rst rst_o=%b expected 00", rst_o); end
  endtask
  initial begin
    test_reset();
    test_table();
    test_query();
    test_pulse();
    test_back_to_back();
    test_errors();
    test_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
